lbp_hist: RTL and testbench



---
 rtl/lbp_pkg.sv | 38 +++
 rtl/lbp_riu2_map.sv | 19 +
 rtl/lbp_hist.sv | 158 +++++++++++++++
 tb/tb_lbp_hist.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and bit helpers for the LBP histogram stage.
package lbp_pkg;

    localparam int IMG_W          = 8;
    localparam int NBINS          = 10;
    localparam int CNT_W          = 6;
    localparam int INTERIOR       = (IMG_W - 2) * (IMG_W - 2);
    localparam int NONUNIFORM_BIN = 9;
    localparam int ADDR_W         = 6;
    localparam int BIN_W          = 4;

    localparam logic [2:0] LAST_RC = 3'(IMG_W - 3);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Interior row/col 0..5 map to image row/col 1..6 of the 8x8 code memory.
    function automatic logic [ADDR_W-1:0] interior_addr(input logic [2:0] r, input logic [2:0] c);
        logic [2:0] rr;
        logic [2:0] cc;
        rr = r + 3'd1;
        cc = c + 3'd1;
        return {rr, cc};
    endfunction

endpackage

// File: rtl/lbp_riu2_map.sv
// Rotation-invariant uniform (riu2) bin for one 8-bit LBP code.
module lbp_riu2_map
    import lbp_pkg::*;
(
    input  logic [7:0]       code,
    output logic [BIN_W-1:0] bin
);

    logic [3:0] ones;
    logic [3:0] trans;

    // Rotating right by one lines code[i+1] up with code[i], wrapping bit 7 to bit 0.
    always_comb begin
        ones  = popcount8(code);
        trans = popcount8(code ^ {code[0], code[7:1]});
        bin   = (trans <= 4'd2) ? ones : 4'(NONUNIFORM_BIN);
    end

endmodule

// File: rtl/lbp_hist.sv
// Reads the 6x6 interior of the LBP code memory, builds a riu2 histogram and writes it out.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | wait for start; finish holds its last value
//  S_READ  | issue 36 interior reads, one per cycle
//  S_DRAIN | no request; last returned code is accumulated
//  S_WRITE | write bins 0..9 to the histogram memory
//  S_DONE  | raise finish, return to idle
module lbp_hist
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] lbp_raddr,
    output logic              lbp_rreq,
    input  logic [7:0]        lbp_rdata,
    output logic [BIN_W-1:0]  hist_addr,
    output logic              hist_write,
    output logic [CNT_W-1:0]  hist_data,
    output logic              finish
);

    logic [2:0]        state_q,   state_d;
    logic [2:0]        row_q,     row_d;
    logic [2:0]        col_q,     col_d;
    logic [BIN_W-1:0]  bin_idx_q, bin_idx_d;
    logic              valid_q,   valid_d;
    logic [CNT_W-1:0]  cnt_q [NBINS];
    logic [CNT_W-1:0]  cnt_d [NBINS];
    logic [ADDR_W-1:0] raddr_q,   raddr_d;
    logic              rreq_q,    rreq_d;
    logic [BIN_W-1:0]  haddr_q,   haddr_d;
    logic              hwrite_q,  hwrite_d;
    logic [CNT_W-1:0]  hdata_q,   hdata_d;
    logic              finish_q,  finish_d;

    logic [BIN_W-1:0]  code_bin;
    logic [2:0]        row_nx;
    logic [2:0]        col_nx;

    lbp_riu2_map u_riu2_map (
        .code (lbp_rdata),
        .bin  (code_bin)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        bin_idx_d = bin_idx_q;
        valid_d   = rreq_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        rreq_d    = 1'b0;
        haddr_d   = haddr_q;
        hwrite_d  = 1'b0;
        hdata_d   = hdata_q;
        finish_d  = finish_q;

        row_nx = (col_q == LAST_RC) ? row_q + 3'd1 : row_q;
        col_nx = (col_q == LAST_RC) ? 3'd0 : col_q + 3'd1;

        if (valid_q && (cnt_q[code_bin] != '1)) begin
            cnt_d[code_bin] = cnt_q[code_bin] + 1'b1;
        end

        // Read requests are registered from the next pixel so each address is on the port during its READ cycle.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    row_d     = 3'd0;
                    col_d     = 3'd0;
                    bin_idx_d = '0;
                    finish_d  = 1'b0;
                    for (int b = 0; b < NBINS; b++) begin
                        cnt_d[b] = '0;
                    end
                    rreq_d  = 1'b1;
                    raddr_d = interior_addr(3'd0, 3'd0);
                end
            end
            S_READ: begin
                if ((row_q == LAST_RC) && (col_q == LAST_RC)) begin
                    state_d = S_DRAIN;
                end else begin
                    row_d   = row_nx;
                    col_d   = col_nx;
                    rreq_d  = 1'b1;
                    raddr_d = interior_addr(row_nx, col_nx);
                end
            end
            S_DRAIN: begin
                state_d   = S_WRITE;
                bin_idx_d = '0;
            end
            S_WRITE: begin
                hwrite_d = 1'b1;
                haddr_d  = bin_idx_q;
                hdata_d  = cnt_q[bin_idx_q];
                if (bin_idx_q == 4'(NBINS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    bin_idx_d = bin_idx_q + 1'b1;
                end
            end
            S_DONE: begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            bin_idx_q <= '0;
            valid_q   <= 1'b0;
            for (int b = 0; b < NBINS; b++) begin
                cnt_q[b] <= '0;
            end
            raddr_q   <= '0;
            rreq_q    <= 1'b0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hdata_q   <= '0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            bin_idx_q <= bin_idx_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            raddr_q   <= raddr_d;
            rreq_q    <= rreq_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hdata_q   <= hdata_d;
            finish_q  <= finish_d;
        end
    end

    assign lbp_raddr  = raddr_q;
    assign lbp_rreq   = rreq_q;
    assign hist_addr  = haddr_q;
    assign hist_write = hwrite_q;
    assign hist_data  = hdata_q;
    assign finish     = finish_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: memory model, histogram scoreboard, read-order log, exhaustive riu2 map sweep.
module tb_lbp_hist;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] lbp_raddr;
    logic       lbp_rreq;
    logic [7:0] lbp_rdata;
    logic [3:0] hist_addr;
    logic       hist_write;
    logic [5:0] hist_data;
    logic       finish;

    logic [7:0] map_code;
    logic [3:0] map_bin;

    always #5 clk = ~clk;

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lbp_raddr  (lbp_raddr),
        .lbp_rreq   (lbp_rreq),
        .lbp_rdata  (lbp_rdata),
        .hist_addr  (hist_addr),
        .hist_write (hist_write),
        .hist_data  (hist_data),
        .finish     (finish)
    );

    lbp_riu2_map u_map (
        .code (map_code),
        .bin  (map_bin)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [5:0] data;
    } wr_t;

    logic [7:0] mem [64];
    wr_t        sb [$];
    logic [5:0] rd_log [$];
    int         checks  = 0;
    int         errors  = 0;
    int         wr_cnt  = 0;
    int         obs_sum = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int riu2_model(input logic [7:0] c);
        int t;
        int ones;
        t = 0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (c[i] != c[(i + 1) % 8]) t++;
            if (c[i]) ones++;
        end
        return (t <= 2) ? ones : 9;
    endfunction

    function automatic int int_addr(input int k);
        return (1 + k / 6) * 8 + (1 + k % 6);
    endfunction

    always @(posedge clk) begin
        if (lbp_rreq) lbp_rdata <= mem[lbp_raddr];
    end

    always @(negedge clk) begin
        if (lbp_rreq) rd_log.push_back(lbp_raddr);
        if (hist_write) begin
            wr_t e;
            wr_cnt++;
            obs_sum += int'(hist_data);
            if (sb.size() == 0) begin
                check_val("extra_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("hist_addr", 32'(hist_addr), 32'(e.addr));
                check_val("hist_data", 32'(hist_data), 32'(e.data));
            end
        end
    end

    task automatic push_expected();
        int h [10];
        wr_t e;
        for (int b = 0; b < 10; b++) h[b] = 0;
        for (int k = 0; k < 36; k++) h[riu2_model(mem[int_addr(k)])]++;
        for (int b = 0; b < 10; b++) begin
            e.addr = 4'(b);
            e.data = 6'(h[b]);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_test(input bit glitch, input bit check_order);
        int cycles;
        int first_wr;
        bit done;
        wr_cnt   = 0;
        obs_sum  = 0;
        rd_log.delete();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles   = 0;
        first_wr = -1;
        done     = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (hist_write && first_wr < 0) first_wr = cycles;
            if (finish) begin
                done = 1'b1;
                break;
            end
            if (glitch && (cycles == 10 || cycles == 40)) start = 1'b1;
            @(posedge clk);
            cycles++;
        end
        start = 1'b0;
        check_val("finish_seen", 32'(done), 32'd1);
        check_val("finish_latency", 32'(cycles), 32'd48);
        check_val("first_write", 32'(first_wr), 32'd38);
        check_val("write_count", 32'(wr_cnt), 32'd10);
        check_val("sum_counts", 32'(obs_sum), 32'd36);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        check_val("read_count", 32'(rd_log.size()), 32'd36);
        if (check_order) begin
            for (int k = 0; k < 36 && k < rd_log.size(); k++) begin
                check_val("read_order", 32'(rd_log[k]), 32'(int_addr(k)));
            end
        end
        repeat (3) @(negedge clk);
        check_val("finish_hold", 32'(finish), 32'd1);
        check_val("idle_no_write", 32'(hist_write), 32'd0);
        check_val("idle_no_rreq", 32'(lbp_rreq), 32'd0);
        sb.delete();
    endtask

    initial begin
        int n_uni;
        int n_nonuni;
        reset    = 1'b1;
        start    = 1'b0;
        map_code = 8'h00;
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_raddr", 32'(lbp_raddr), 32'd0);
        check_val("rst_rreq", 32'(lbp_rreq), 32'd0);
        check_val("rst_haddr", 32'(hist_addr), 32'd0);
        check_val("rst_hwrite", 32'(hist_write), 32'd0);
        check_val("rst_hdata", 32'(hist_data), 32'd0);
        check_val("rst_finish", 32'(finish), 32'd0);
        reset = 1'b0;

        n_uni = 0;
        n_nonuni = 0;
        for (int c = 0; c < 256; c++) begin
            map_code = 8'(c);
            #1;
            check_val("riu2_map", 32'(map_bin), 32'(riu2_model(8'(c))));
            if (map_bin == 4'd9) n_nonuni++;
            else if (map_bin <= 4'd8) n_uni++;
        end
        check_val("riu2_uniform", 32'(n_uni), 32'd58);
        check_val("riu2_nonuniform", 32'(n_nonuni), 32'd198);

        run_test(1'b0, 1'b0);

        for (int a = 0; a < 64; a++) begin
            mem[a] = ((a / 8) == 0 || (a / 8) == 7 || (a % 8) == 0 || (a % 8) == 7) ? 8'h55 : 8'hFF;
        end
        run_test(1'b0, 1'b1);

        for (int r = 1; r <= 6; r++) begin
            logic [7:0] rc;
            case (r)
                1: rc = 8'h01;
                2: rc = 8'h03;
                3: rc = 8'h0F;
                4: rc = 8'h55;
                5: rc = 8'h81;
                default: rc = 8'h7E;
            endcase
            for (int c = 1; c <= 6; c++) mem[r * 8 + c] = rc;
        end
        run_test(1'b0, 1'b0);

        for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
        run_test(1'b1, 1'b1);

        pulse_start();
        repeat (19) @(negedge clk);
        check_val("abort_in_read", 32'(lbp_rreq), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_rreq", 32'(lbp_rreq), 32'd0);
        check_val("abort_hwrite", 32'(hist_write), 32'd0);
        check_val("abort_raddr", 32'(lbp_raddr), 32'd0);
        check_val("abort_finish", 32'(finish), 32'd0);
        repeat (5) @(negedge clk);
        check_val("abort_quiet", 32'(lbp_rreq | hist_write), 32'd0);

        for (int a = 0; a < 64; a++) mem[a] = ((a % 3) == 0) ? 8'h07 : 8'($urandom_range(0, 255));
        run_test(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
